div_unit: RTL

- Multi-cycle radix-2 restoring divider for the EX stage of the MIPS pipeline.
- Serves DIV/DIVU, one quotient bit per cycle; result feeds the EX result/HILO select mux alongside ALU and multiplier results.
- The hazard unit stalls the pipeline while start=1 and ready=0.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between the EX stage and the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   annul;
  logic                   signed_div;
  logic [WIDTH-1:0]       opdata1;
  logic [WIDTH-1:0]       opdata2;
  logic [2*WIDTH-1:0]     result;
  logic                   ready;
  logic                   busy;

  modport master (
    output start, annul, signed_div, opdata1, opdata2,
    input  result, ready, busy
  );

  modport slave (
    input  start, annul, signed_div, opdata1, opdata2,
    output result, ready, busy
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; one quotient bit is produced per ON cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      resetn,
  div_unit_if.slave dif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   dvd, dvd_n, dsr, dsr_n;
  logic [WIDTH:0]     rem, rem_n;
  logic               qneg, qneg_n, rneg, rneg_n;
  logic [2*WIDTH-1:0] result_q, result_n;
  logic               ready_q, ready_n, busy_q, busy_n;

  logic [WIDTH+1:0]   trial;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   dvd_step, rem_fix, quo_fix, mag1, mag2;
  logic               abort;

  // One restoring step: dvd doubles as the quotient shift register.
  always_comb begin
    trial = {rem, dvd[WIDTH-1]} - {2'b00, dsr};
    if (!trial[WIDTH+1]) begin
      rem_step = trial[WIDTH:0];
      dvd_step = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem[WIDTH-1:0], dvd[WIDTH-1]};
      dvd_step = {dvd[WIDTH-2:0], 1'b0};
    end
    rem_fix = rneg ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
    quo_fix = qneg ? -dvd_step : dvd_step;
    mag1    = (dif.signed_div && dif.opdata1[WIDTH-1]) ? -dif.opdata1 : dif.opdata1;
    mag2    = (dif.signed_div && dif.opdata2[WIDTH-1]) ? -dif.opdata2 : dif.opdata2;
    abort   = dif.annul || !dif.start;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dvd_n    = dvd;
    dsr_n    = dsr;
    rem_n    = rem;
    qneg_n   = qneg;
    rneg_n   = rneg;
    result_n = result_q;
    ready_n  = ready_q;
    case (state)
      IDLE: begin
        if (dif.start && !dif.annul) begin
          dvd_n   = mag1;
          dsr_n   = mag2;
          rem_n   = '0;
          cnt_n   = '0;
          qneg_n  = dif.signed_div & (dif.opdata1[WIDTH-1] ^ dif.opdata2[WIDTH-1]);
          rneg_n  = dif.signed_div & dif.opdata1[WIDTH-1];
          state_n = (dif.opdata2 == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n  = END;
          result_n = '0;
          ready_n  = 1'b1;
        end
      end
      ON: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          rem_n = rem_step;
          dvd_n = dvd_step;
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_n  = END;
            result_n = {rem_fix, quo_fix};
            ready_n  = 1'b1;
          end
        end
      end
      END: begin
        // Result is held for as long as EX keeps start high; annul has no effect here.
        if (!dif.start) begin
          state_n  = IDLE;
          cnt_n    = '0;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == DIVZERO) || (state_n == ON);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dsr      <= dsr_n;
      rem      <= rem_n;
      qneg     <= qneg_n;
      rneg     <= rneg_n;
      result_q <= result_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
    end
  end

  assign dif.result = result_q;
  assign dif.ready  = ready_q;
  assign dif.busy   = busy_q;
endmodule
